sysarray_result_drain: RTL and testbench

//  Downstream of the add/mean systolic stage. On a capture pulse it snapshots both 4x4

---
 rtl/sysarray_result_drain_pkg.sv | 20 ++
 rtl/sysarray_result_drain_drain_buffer.sv | 33 +++
 rtl/sysarray_result_drain.sv | 157 +++++++++++++++
 tb/tb_sysarray_result_drain.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysarray_result_drain_pkg.sv
// Shared types and constants for the systolic-array result drain.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sysarray_result_drain_pkg;

  // Words captured per head: two 4x4 result matrices.
  localparam int ELEMS = 32;
  // Words per matrix. res1 fills k=0..HALF-1 and res2 fills k=HALF..ELEMS-1.
  localparam int HALF  = 16;
  // Width of the word index k.
  localparam int K_W   = $clog2(ELEMS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_SKIP   = 2'd2,
    ST_NEXT   = 2'd3
  } state_t;

endpackage

// File: rtl/sysarray_result_drain_drain_buffer.sv
// Drain buffer: a 32-word snapshot register file with a parallel load port and a
//   combinational read port. Latency: load visible the cycle after load=1; read is 0-cycle.
// Backpressure: none; the owner decides when to load and which word to read.
// Ports:
//   clk      rising-edge clock
//   load     when 1, all ELEMS words are overwritten from load_dat
//   load_dat ELEMS words of DW bits, word k at index k
//   rd_idx   word index for the read port
//   rd_dat   word at rd_idx
module sysarray_result_drain_drain_buffer
  import sysarray_result_drain_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                      clk,
  input  logic                      load,
  input  logic [ELEMS-1:0][DW-1:0]  load_dat,
  input  logic [K_W-1:0]            rd_idx,
  output logic [DW-1:0]             rd_dat
);

  // Contents have no meaning until the first load, so the array carries no reset.
  logic [ELEMS-1:0][DW-1:0] mem;

  always_ff @(posedge clk) begin
    if (load) begin
      mem <= load_dat;
    end
  end

  assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/sysarray_result_drain.sv
// Snapshots both 4x4 result matrices on capture and streams unpruned heads out word by
//   word with a write address. Latency: first word valid 1 cycle after capture.
// Backpressure: valid/ready; while out_valid && !out_ready the word, address and last hold.
// Ports:
//   clk, _reset              clock, asynchronous active-low reset
//   capture, prune_head      1-cycle snapshot strobe and that head's prune decision
//   res1_flat, res2_flat     16 words each, word k at [k*2w +: 2w]
//   out_valid/out_ready      output handshake
//   out_data/out_addr/out_last  word, head_idx*32+k, high on k=31
//   busy                     not idle
//   head_idx                 head the next capture is assigned to
//   prune_mask               bit h set if head h was pruned in the current pass
//   pass_done                1-cycle pulse when the last head of a pass retires
//   overrun                  sticky: a capture arrived while busy and was dropped
module sysarray_result_drain
  import sysarray_result_drain_pkg::*;
#(
  parameter int width  = 8,
  parameter int HEADS  = 4,
  parameter int ADDR_W = 8,
  localparam int HW    = (HEADS > 1) ? $clog2(HEADS) : 1
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  capture,
  input  logic                  prune_head,
  input  logic [32*width-1:0]   res1_flat,
  input  logic [32*width-1:0]   res2_flat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*width-1:0]    out_data,
  output logic [ADDR_W-1:0]     out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic [HW-1:0]         head_idx,
  output logic [HEADS-1:0]      prune_mask,
  output logic                  pass_done,
  output logic                  overrun
);

  localparam int DW = 2 * width;

  state_t                  state, state_nxt;
  logic [K_W-1:0]          k, k_nxt;
  logic [HW-1:0]           head_q, head_nxt;
  logic [HEADS-1:0]        mask_q, mask_nxt;
  logic                    overrun_q, overrun_nxt;
  logic                    load;
  logic [ELEMS-1:0][DW-1:0] words;
  logic [DW-1:0]           rd_dat;
  logic [ADDR_W-1:0]       addr_raw;

  // Unpack both matrices into one word array: res1 at k=0..15, res2 at k=16..31.
  always_comb begin
    words = '0;
    for (int i = 0; i < HALF; i++) begin
      words[i]        = res1_flat[i*DW +: DW];
      words[i + HALF] = res2_flat[i*DW +: DW];
    end
  end

  sysarray_result_drain_drain_buffer #(
    .DW (DW)
  ) u_drain_buffer (
    .clk      (clk),
    .load     (load),
    .load_dat (words),
    .rd_idx   (k),
    .rd_dat   (rd_dat)
  );

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state     <= ST_IDLE;
      k         <= '0;
      head_q    <= '0;
      mask_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      k         <= k_nxt;
      head_q    <= head_nxt;
      mask_q    <= mask_nxt;
      overrun_q <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    k_nxt       = k;
    head_nxt    = head_q;
    mask_nxt    = mask_q;
    overrun_nxt = overrun_q;
    load        = 1'b0;
    out_valid   = 1'b0;
    pass_done   = 1'b0;

    // A capture outside IDLE is dropped; only the sticky flag records it.
    if (capture && (state != ST_IDLE)) begin
      overrun_nxt = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (capture) begin
          load = 1'b1;
          // Head 0 opens a new pass, so stale bits from the previous pass go.
          if (head_q == '0) begin
            mask_nxt = '0;
          end
          mask_nxt[head_q] = prune_head;
          k_nxt            = '0;
          state_nxt        = prune_head ? ST_SKIP : ST_STREAM;
        end
      end
      ST_STREAM: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (k == K_W'(ELEMS - 1)) begin
            state_nxt = ST_NEXT;
          end else begin
            k_nxt = k + K_W'(1);
          end
        end
      end
      ST_SKIP: begin
        state_nxt = ST_NEXT;
      end
      ST_NEXT: begin
        state_nxt = ST_IDLE;
        if (head_q == HW'(HEADS - 1)) begin
          head_nxt  = '0;
          pass_done = 1'b1;
        end else begin
          head_nxt = head_q + HW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Unsigned, truncated to ADDR_W.
  assign addr_raw = ADDR_W'(head_q) * ADDR_W'(ELEMS) + ADDR_W'(k);

  // Gated by out_valid so the outputs read 0 while idle, including straight after
  // reset when the buffer holds nothing meaningful.
  assign out_data   = out_valid ? rd_dat : '0;
  assign out_addr   = out_valid ? addr_raw : '0;
  assign out_last   = out_valid && (k == K_W'(ELEMS - 1));
  assign busy       = (state != ST_IDLE);
  assign head_idx   = head_q;
  assign prune_mask = mask_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sysarray_result_drain.sv
module tb_sysarray_result_drain;

  localparam int WIDTH  = 8;
  localparam int HEADS  = 4;
  localparam int ADDR_W = 8;

  logic                  clk = 1'b0;
  logic                  _reset;
  logic                  capture;
  logic                  prune_head;
  logic [32*WIDTH-1:0]   res1_flat;
  logic [32*WIDTH-1:0]   res2_flat;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [2*WIDTH-1:0]    out_data;
  logic [ADDR_W-1:0]     out_addr;
  logic                  out_last;
  logic                  busy;
  logic [1:0]            head_idx;
  logic [HEADS-1:0]      prune_mask;
  logic                  pass_done;
  logic                  overrun;

  sysarray_result_drain #(
    .width  (WIDTH),
    .HEADS  (HEADS),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    ._reset     (_reset),
    .capture    (capture),
    .prune_head (prune_head),
    .res1_flat  (res1_flat),
    .res2_flat  (res2_flat),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .busy       (busy),
    .head_idx   (head_idx),
    .prune_mask (prune_mask),
    .pass_done  (pass_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [7:0]  a;
    logic        l;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  beat_t log_q[$];
  int    m_head = 0;
  logic [HEADS-1:0] m_mask = '0;
  logic  m_ovr = 1'b0;
  int    m_pass = 0;
  int    pass_cnt = 0;
  bit    rdy_mode = 1'b0;
  int    rcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word k of stimulus pattern pat; pattern 0 is res1_k=k, res2_k=-k.
  function automatic logic [15:0] word(input int pat, input int k);
    if (pat == 0) return (k < 16) ? 16'(k) : 16'(-(k - 16));
    return (k < 16) ? 16'(pat * 256 + k) : 16'(32768 + pat * 256 + (k - 16));
  endfunction

  // Drives one capture pulse. acc says whether the DUT is idle and must take it.
  task automatic cap(input bit pr, input int pat, input bit acc);
    beat_t b;
    @(posedge clk); #1;
    for (int k = 0; k < 32; k++) begin
      if (k < 16) res1_flat[k*16 +: 16] = word(pat, k);
      else        res2_flat[(k-16)*16 +: 16] = word(pat, k);
    end
    prune_head = pr;
    capture    = 1'b1;
    if (acc) begin
      if (m_head == 0) m_mask = '0;
      m_mask[m_head] = pr;
      if (!pr) begin
        for (int k = 0; k < 32; k++) begin
          b.d = word(pat, k);
          b.a = 8'((m_head * 32 + k) % 256);
          b.l = (k == 31);
          exp_q.push_back(b);
        end
      end
      if (m_head == HEADS - 1) m_pass++;
      m_head = (m_head + 1) % HEADS;
    end else begin
      m_ovr = 1'b1;
    end
    @(posedge clk); #1;
    capture    = 1'b0;
    prune_head = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", n);
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  // Ready driver: tied high, or a 1-0-0 repeating pattern.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode) begin
        out_ready = (rcnt % 3 == 0);
        rcnt++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Every valid cycle is checked against the head of the expected-beat queue.
  always @(negedge clk) begin
    if (_reset === 1'b1) begin
      if (pass_done) pass_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: out_valid=1 addr=%0h, required out_valid=0", out_addr);
        end else begin
          chk("beat_data", out_data, exp_q[0].d);
          chk("beat_addr", out_addr, exp_q[0].a);
          chk("beat_last", out_last, exp_q[0].l);
          if (out_ready) begin
            beat_t b;
            b.d = out_data; b.a = out_addr; b.l = out_last;
            log_q.push_back(b);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p0;
    int n;
    _reset = 1'b0; capture = 1'b0; prune_head = 1'b0;
    res1_flat = '0; res2_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pass_done", pass_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_head_idx", head_idx, 0);
    chk("rst_prune_mask", prune_mask, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_addr", out_addr, 0);
    @(negedge clk);
    _reset = 1'b1;

    // Head 0 streamed with ready tied high.
    log_q.delete();
    cap(0, 0, 1);
    wait_idle();
    chk("s1_beats", log_q.size(), 32);
    chk("s1_d0", log_q[0].d, 16'h0000);
    chk("s1_d15", log_q[15].d, 16'h000F);
    chk("s1_d16", log_q[16].d, 16'h0000);
    chk("s1_d17", log_q[17].d, 16'hFFFF);
    chk("s1_d31", log_q[31].d, 16'hFFF1);
    chk("s1_a31", log_q[31].a, 31);
    chk("s1_last30", log_q[30].l, 0);
    chk("s1_last31", log_q[31].l, 1);
    chk("s1_head", head_idx, 2'd1);
    chk("s1_mask", prune_mask, 4'b0000);

    // Head 1 pruned: busy only in SKIP and NEXT, no beats.
    cap(1, 1, 1);
    @(negedge clk); chk("s3_busy_skip", busy, 1);
    @(negedge clk); chk("s3_busy_next", busy, 1);
    @(negedge clk); chk("s3_idle", busy, 0);
    chk("s3_mask", prune_mask, 4'b0010);
    chk("s3_head", head_idx, 2'd2);

    // Head 2 with ready 1-0-0.
    log_q.delete();
    rcnt = 0;
    rdy_mode = 1'b1;
    cap(0, 2, 1);
    wait_idle();
    rdy_mode = 1'b0;
    chk("s2_accepts", log_q.size(), 32);
    chk("s2_first_addr", log_q[0].a, 64);
    chk("s2_last_addr", log_q[31].a, 95);
    chk("s2_head", head_idx, m_head);

    // Head 3 closes the pass.
    cap(0, 3, 1);
    wait_idle();
    chk("pass1_done", pass_cnt, 1);
    chk("pass1_head", head_idx, 0);
    chk("pass1_mask", prune_mask, m_mask);

    // Full pass with prune 0,1,0,1.
    p0 = pass_cnt;
    for (int h = 0; h < 4; h++) begin
      if (h == 2) log_q.delete();
      cap(h[0], 10 + h, 1);
      wait_idle();
    end
    chk("s4_mask", prune_mask, 4'b1010);
    chk("s4_mask_model", prune_mask, m_mask);
    chk("s4_head", head_idx, 0);
    chk("s4_pass_pulses", pass_cnt - p0, 1);
    chk("s4_pass_model", pass_cnt, m_pass);
    chk("s4_h2_beats", log_q.size(), 32);
    chk("s4_h2_first", log_q[0].a, 64);
    chk("s4_h2_last", log_q[31].a, 95);

    // Capture during STREAM is dropped and flagged.
    chk("s5_ovr_before", overrun, 0);
    cap(0, 5, 1);
    repeat (5) @(posedge clk);
    cap(0, 6, 0);
    @(negedge clk);
    chk("s5_ovr_set", overrun, m_ovr);
    wait_idle();
    chk("s5_ovr_sticky", overrun, 1);
    chk("s5_mask", prune_mask, 4'b0000);
    chk("s5_head", head_idx, 1);

    // Reset after 10 accepted beats.
    log_q.delete();
    cap(0, 7, 1);
    n = 0;
    @(negedge clk); #1;
    while (log_q.size() < 10 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("s6_beats_before_rst", log_q.size(), 10);
    _reset = 1'b0;
    #1;
    chk("s6_valid", out_valid, 0);
    chk("s6_busy", busy, 0);
    chk("s6_head", head_idx, 0);
    chk("s6_mask", prune_mask, 0);
    chk("s6_ovr", overrun, 0);
    exp_q.delete();
    m_head = 0; m_mask = '0; m_ovr = 1'b0;
    @(negedge clk);
    _reset = 1'b1;
    log_q.delete();
    cap(0, 8, 1);
    wait_idle();
    chk("s6_new_beats", log_q.size(), 32);
    chk("s6_new_addr0", log_q[0].a, 0);
    chk("s6_new_data0", log_q[0].d, 16'h0800);
    chk("s6_new_head", head_idx, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
